// File: rtl/riscv_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RISC-V pipeline: load-use stall,
// multi-cycle load hold, branch-redirect flush and EX operand forward selects.
module riscv_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              ex_redirect_i,
   output logic              stall_front_o,
   output logic              bubble_ex_o,
   output logic              stall_ex_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic [1:0]        forward_a_o,
   output logic [1:0]        forward_b_o
);

   localparam int CNT_W = 4;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              regwrite;
      logic              memread;
   } ex_entry_t;

   // Source-register fields are only consulted in EX, so later stages drop them.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } mem_entry_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
   } wb_entry_t;

   ex_entry_t        ex_q, ex_d;
   mem_entry_t       mem_q, mem_d;
   wb_entry_t        wb_q, wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic hold, rs1_hit, rs2_hit, load_use, flush, bubble;

   function automatic logic writes_reg(input logic v, input logic rw,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
      return v && rw && (rd == r) && (rd != '0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r,
                                          input mem_entry_t m,
                                          input wb_entry_t w);
      if (writes_reg(m.valid, m.regwrite, m.rd, r) && !m.memread) return 2'b10;
      if (writes_reg(w.valid, w.regwrite, w.rd, r)) return 2'b01;
      return 2'b00;
   endfunction

   always_comb begin
      hold     = (cnt_q != '0);
      rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_q.rd) && (ex_q.rd != '0);
      rs2_hit  = id_rs2_used_i && (id_rs2_i == ex_q.rd) && (ex_q.rd != '0);
      load_use = ex_q.valid && ex_q.memread && (rs1_hit || rs2_hit);
      flush    = ex_redirect_i && ex_q.valid && !hold;
      bubble   = !hold && load_use && id_valid_i && !ex_redirect_i;

      stall_front_o = hold || (load_use && id_valid_i && !ex_redirect_i);
      bubble_ex_o   = bubble;
      stall_ex_o    = hold;
      flush_if_id_o = flush;
      flush_id_ex_o = flush;
      forward_a_o   = fwd_sel(ex_q.rs1, mem_q, wb_q);
      forward_b_o   = fwd_sel(ex_q.rs2, mem_q, wb_q);

      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
      if (hold) begin
         wb_d  = '0;
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         wb_d.valid     = mem_q.valid;
         wb_d.rd        = mem_q.rd;
         wb_d.regwrite  = mem_q.regwrite;
         mem_d.valid    = ex_q.valid;
         mem_d.rd       = ex_q.rd;
         mem_d.regwrite = ex_q.regwrite;
         mem_d.memread  = ex_q.memread;
         cnt_d = (ex_q.valid && ex_q.memread) ? CNT_W'(LOAD_LAT - 1) : '0;
         if (flush || bubble || !id_valid_i) begin
            ex_d = '0;
         end else begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd_i;
            ex_d.rs1      = id_rs1_i;
            ex_d.rs2      = id_rs2_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Scoreboard bench: dut 0 runs with LOAD_LAT=1, dut 1 with LOAD_LAT=3. Expected output
// vector {stall_front, bubble_ex, stall_ex, flush_if_id, flush_id_ex, fwd_a, fwd_b}.
module tb_riscv_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid    [2];
   logic [4:0] id_rs1      [2];
   logic [4:0] id_rs2      [2];
   logic       id_rs1_used [2];
   logic       id_rs2_used [2];
   logic [4:0] id_rd       [2];
   logic       id_regwrite [2];
   logic       id_memread  [2];
   logic       ex_redirect [2];
   logic       stall_front [2];
   logic       bubble_ex   [2];
   logic       stall_ex    [2];
   logic       flush_if_id [2];
   logic       flush_id_ex [2];
   logic [1:0] forward_a   [2];
   logic [1:0] forward_b   [2];

   typedef struct {
      int         sel;
      logic [8:0] exp;
      string      name;
   } sb_t;

   sb_t sb[$];
   int  total = 0;
   int  bad   = 0;

   localparam logic [8:0] Z    = 9'b0_0_0_0_0_00_00;
   localparam logic [8:0] LU   = 9'b1_1_0_0_0_00_00;
   localparam logic [8:0] FL   = 9'b0_0_0_1_1_00_00;
   localparam logic [8:0] HOLD = 9'b1_0_1_0_0_00_00;

   always #5 clk = ~clk;

   riscv_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1)) dut0 (
      .clk_i(clk), .reset_i(reset),
      .id_valid_i(id_valid[0]), .id_rs1_i(id_rs1[0]), .id_rs2_i(id_rs2[0]),
      .id_rs1_used_i(id_rs1_used[0]), .id_rs2_used_i(id_rs2_used[0]),
      .id_rd_i(id_rd[0]), .id_regwrite_i(id_regwrite[0]), .id_memread_i(id_memread[0]),
      .ex_redirect_i(ex_redirect[0]),
      .stall_front_o(stall_front[0]), .bubble_ex_o(bubble_ex[0]), .stall_ex_o(stall_ex[0]),
      .flush_if_id_o(flush_if_id[0]), .flush_id_ex_o(flush_id_ex[0]),
      .forward_a_o(forward_a[0]), .forward_b_o(forward_b[0]));

   riscv_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3)) dut1 (
      .clk_i(clk), .reset_i(reset),
      .id_valid_i(id_valid[1]), .id_rs1_i(id_rs1[1]), .id_rs2_i(id_rs2[1]),
      .id_rs1_used_i(id_rs1_used[1]), .id_rs2_used_i(id_rs2_used[1]),
      .id_rd_i(id_rd[1]), .id_regwrite_i(id_regwrite[1]), .id_memread_i(id_memread[1]),
      .ex_redirect_i(ex_redirect[1]),
      .stall_front_o(stall_front[1]), .bubble_ex_o(bubble_ex[1]), .stall_ex_o(stall_ex[1]),
      .flush_if_id_o(flush_if_id[1]), .flush_id_ex_o(flush_id_ex[1]),
      .forward_a_o(forward_a[1]), .forward_b_o(forward_b[1]));

   function automatic logic [8:0] actual(input int s);
      return {stall_front[s], bubble_ex[s], stall_ex[s], flush_if_id[s], flush_id_ex[s],
              forward_a[s], forward_b[s]};
   endfunction

   // Drive one cycle of ID/EX inputs for the selected dut (the other idles), queue the
   // expected outputs for that cycle, then advance to just after the next rising edge.
   task automatic cyc(input int sel, input string name, input logic v,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic rw,
                      input logic mr, input logic redir, input logic [8:0] exp);
      sb_t e;
      for (int s = 0; s < 2; s++) begin
         id_valid[s]    = (s == sel) ? v     : 1'b0;
         id_rd[s]       = (s == sel) ? rd    : 5'd0;
         id_rs1[s]      = (s == sel) ? rs1   : 5'd0;
         id_rs1_used[s] = (s == sel) ? u1    : 1'b0;
         id_rs2[s]      = (s == sel) ? rs2   : 5'd0;
         id_rs2_used[s] = (s == sel) ? u2    : 1'b0;
         id_regwrite[s] = (s == sel) ? rw    : 1'b0;
         id_memread[s]  = (s == sel) ? mr    : 1'b0;
         ex_redirect[s] = (s == sel) ? redir : 1'b0;
      end
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int sel, input string name, input logic [8:0] exp);
      cyc(sel, name, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
   endtask

   initial begin : monitor
      sb_t e;
      logic [8:0] got;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = actual(e.sel);
            total++;
            if (got !== e.exp) begin
               bad++;
               $display("FAIL %s: dut%0d got %b want %b", e.name, e.sel, got, e.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not finish, total=%0d", total);
      $fatal(1, "timeout");
   end

   initial begin : driver
      reset = 1'b1;
      for (int s = 0; s < 2; s++) begin
         id_valid[s] = 1'b1;    id_rd[s] = 5'd5;       id_rs1[s] = 5'd5;
         id_rs1_used[s] = 1'b1; id_rs2[s] = 5'd5;      id_rs2_used[s] = 1'b1;
         id_regwrite[s] = 1'b1; id_memread[s] = 1'b1;  ex_redirect[s] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      //      sel name           v  rd  rs1 u1 rs2 u2 rw mr rd  expected
      cyc(0, "rst_release",  1, 3,  0,  1, 0,  0, 1, 0, 0, Z);
      cyc(0, "alu_c1",       1, 1,  0,  1, 0,  0, 1, 0, 0, Z);
      cyc(0, "alu_c2",       1, 2,  1,  1, 0,  0, 1, 0, 0, Z);
      cyc(0, "fwd_a_mem",    1, 4,  1,  1, 0,  1, 1, 0, 0, 9'b0_0_0_0_0_10_00);
      idle(0, "fwd_a_wb",                                     9'b0_0_0_0_0_01_00);
      idle(0, "drain1",                                       Z);
      cyc(0, "lu_load",      1, 5,  10, 1, 0,  0, 1, 1, 0, Z);
      cyc(0, "lu_stall",     1, 6,  5,  1, 7,  1, 1, 0, 0, LU);
      cyc(0, "lu_bubble",    1, 6,  5,  1, 7,  1, 1, 0, 0, Z);
      cyc(0, "lu_fwd_wb",    1, 9,  8,  1, 0,  1, 1, 0, 0, 9'b0_0_0_0_0_01_00);
      cyc(0, "lw_again",     1, 5,  10, 1, 0,  0, 1, 1, 0, Z);
      cyc(0, "no_stall_x8",  1, 11, 8,  1, 0,  1, 1, 0, 0, Z);
      cyc(0, "no_fwd_other", 1, 12, 0,  1, 0,  1, 1, 0, 0, Z);
      cyc(0, "lw_x0",        1, 0,  10, 1, 0,  0, 1, 1, 0, Z);
      cyc(0, "no_stall_x0",  1, 13, 0,  1, 0,  1, 1, 0, 0, Z);
      idle(0, "drain2",                                       Z);
      cyc(0, "lw_x7",        1, 7,  10, 1, 0,  0, 1, 1, 0, Z);
      cyc(0, "lu_rs2",       1, 14, 1,  1, 7,  1, 1, 0, 0, LU);
      cyc(0, "lu_rs2_bub",   1, 14, 1,  1, 7,  1, 1, 0, 0, Z);
      idle(0, "fwd_b_wb",                                     9'b0_0_0_0_0_00_01);
      cyc(0, "redir_no_ex",  1, 5,  10, 1, 0,  0, 1, 1, 1, Z);
      cyc(0, "redir_flush",  1, 6,  5,  1, 7,  1, 1, 0, 1, FL);
      cyc(0, "redir_ex_inv", 1, 15, 6,  1, 0,  1, 1, 0, 0, Z);
      idle(0, "redir_killed",                                 Z);
      cyc(0, "x0_write",     1, 0,  0,  1, 0,  0, 1, 0, 0, Z);
      cyc(0, "x0_read",      1, 1,  0,  1, 0,  1, 1, 0, 0, Z);
      idle(0, "x0_no_fwd",                                    Z);
      idle(0, "drain3",                                       Z);

      cyc(1, "l3_addi",      1, 2,  0,  1, 0,  0, 1, 0, 0, Z);
      cyc(1, "l3_lw",        1, 5,  10, 1, 0,  0, 1, 1, 0, Z);
      cyc(1, "l3_indep",     1, 6,  5,  0, 2,  1, 1, 0, 0, Z);
      cyc(1, "l3_hold1",     1, 7,  5,  1, 0,  1, 1, 0, 0, 9'b1_0_1_0_0_00_01);
      cyc(1, "l3_hold2",     1, 7,  5,  1, 0,  1, 1, 0, 1, HOLD);
      cyc(1, "l3_redir",     1, 7,  5,  1, 0,  1, 1, 0, 1, FL);
      idle(1, "l3_after",                                     Z);
      cyc(1, "rh_lw",        1, 5,  10, 1, 0,  0, 1, 1, 0, Z);
      idle(1, "rh_ex",                                        Z);
      idle(1, "rh_hold",                                      HOLD);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1, "rh_after_rst",                                 Z);
      cyc(1, "bb_lw1",       1, 5,  10, 1, 0,  0, 1, 1, 0, Z);
      cyc(1, "bb_lw2",       1, 6,  11, 1, 0,  0, 1, 1, 0, Z);
      idle(1, "bb_h1",                                        HOLD);
      idle(1, "bb_h2",                                        HOLD);
      idle(1, "bb_move",                                      Z);
      idle(1, "bb_h3",                                        HOLD);
      idle(1, "bb_h4",                                        HOLD);
      idle(1, "bb_done",                                      Z);

      for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
